// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field layout, memory size and loader FSM states.
// The PAD state only exists when PROG_LOADER_HALT_PAD_EN is defined.
package cpu_pkg;

    localparam int INST_W     = 20;
    localparam int IMEM_DEPTH = 32;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 18;
    localparam int SRC1_MSB = 17;
    localparam int SRC1_LSB = 12;
    localparam int SRC2_MSB = 11;
    localparam int SRC2_LSB = 6;
    localparam int DST_MSB  = 5;
    localparam int DST_LSB  = 0;

    localparam logic [INST_W-1:0] HALT_WORD = {OP_HALT, 18'h00000};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
`ifdef PROG_LOADER_HALT_PAD_EN
        PAD  = 3'd2,
`endif
        RUN  = 3'd3,
        DONE = 3'd4
    } loader_state_e;

`ifdef PROG_LOADER_HALT_PAD_EN
    localparam loader_state_e LOAD_EXIT = PAD;
`else
    localparam loader_state_e LOAD_EXIT = RUN;
`endif

    function automatic logic is_busy(input loader_state_e s);
        logic b;
        case (s)
            LOAD, RUN: b = 1'b1;
`ifdef PROG_LOADER_HALT_PAD_EN
            PAD:       b = 1'b1;
`endif
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/inst_assembler.sv
// Packs three little-endian host bytes into one instruction word; byte2 supplies only its low nibble.
module inst_assembler #(
    parameter int INST_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              take,
    input  logic              last,
    input  logic [7:0]        byte_in,
    output logic              word_done,
    output logic [INST_W-1:0] word
);
    import cpu_pkg::*;

    logic [1:0] idx_q, idx_d;
    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;

    // Byte index advance; a last flag on a partial word drops it and rewinds the index.
    always_comb begin
        idx_d = idx_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        if (clear) begin
            idx_d = 2'd0;
        end else if (take) begin
            case (idx_q)
                2'd0: begin
                    b0_d  = byte_in;
                    idx_d = last ? 2'd0 : 2'd1;
                end
                2'd1: begin
                    b1_d  = byte_in;
                    idx_d = last ? 2'd0 : 2'd2;
                end
                default: idx_d = 2'd0;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Byte index and low-byte holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
            b0_q  <= 8'h00;
            b1_q  <= 8'h00;
        end else begin
            idx_q <= idx_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
        end
    end

    assign word_done = take && (idx_q == 2'd2);
    assign word      = {byte_in[INST_W-17:0], b1_q, b0_q};

endmodule

// File: rtl/prog_loader.sv
// Program loader: writes host bytes into instruction memory, then runs the CPU until it halts.
// Define PROG_LOADER_HALT_PAD_EN to append a HALT word after every complete program.
module prog_loader #(
    parameter int INST_W     = 20,
    parameter int IMEM_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        host_valid,
    input  logic [7:0]                  host_data,
    input  logic                        host_last,
    output logic                        host_ready,
    output logic                        inst_wr_en,
    output logic [$clog2(IMEM_DEPTH)-1:0] inst_wr_addr,
    output logic [INST_W-1:0]           inst_wr_data,
    output logic                        cpu_run,
    input  logic                        cpu_halted,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(IMEM_DEPTH):0] inst_count
);
    import cpu_pkg::*;

    localparam int ADDR_W = $clog2(IMEM_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH);

    loader_state_e     state_q, state_d;
    logic              host_ready_q, host_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_run_q, cpu_run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              take_s;
    logic              start_ok_s;
    logic              room_s;
    logic              word_done_s;
    logic [INST_W-1:0] word_s;

    assign take_s     = host_valid && host_ready_q;
    assign start_ok_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign room_s     = (count_q < DEPTH_C);

    inst_assembler #(.INST_W(INST_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok_s),
        .take      (take_s),
        .last      (host_last),
        .byte_in   (host_data),
        .word_done (word_done_s),
        .word      (word_s)
    );

    // Next-state, write strobe, address/count and error logic.
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        count_d   = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    wr_addr_d = {ADDR_W{1'b0}};
                    count_d   = {CNT_W{1'b0}};
                    err_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (word_done_s) begin
                    if (room_s) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q[ADDR_W-1:0];
                        wr_data_d = word_s;
                        count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = host_last ? LOAD_EXIT : LOAD;
                end else if (take_s && host_last) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
`ifdef PROG_LOADER_HALT_PAD_EN
            PAD: begin
                if (room_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = INST_W'(HALT_WORD);
                    count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    wr_en_d = 1'b0;
                end
                state_d = RUN;
            end
`endif
            RUN: begin
                // Halted is only trusted once the CPU has actually been released to run.
                if (cpu_run_q && cpu_halted) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered views of the upcoming state.
    always_comb begin
        host_ready_d = (state_d == LOAD);
        busy_d       = is_busy(state_d);
        done_d       = (state_d == DONE);
        cpu_run_d    = (state_q == RUN) && (state_d == RUN);
    end

    // Single state and output register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            host_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_data_q    <= {INST_W{1'b0}};
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            host_ready_q <= host_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_run_q    <= cpu_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    assign host_ready   = host_ready_q;
    assign inst_wr_en   = wr_en_q;
    assign inst_wr_addr = wr_addr_q;
    assign inst_wr_data = wr_data_q;
    assign cpu_run      = cpu_run_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign inst_count   = count_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter INST_W, default 20, instruction width in bits.
REQ-002 Parameter IMEM_DEPTH, default 32, number of instruction memory words.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins a load session (only honoured in IDLE or DONE).
REQ-006 host_valid  input  1  host byte valid.
REQ-007 host_data  input  8  host program byte.
REQ-008 host_last  input  1  qualifies the final byte of the program.
REQ-009 host_ready  output  1  loader accepts a byte this cycle.
REQ-010 inst_wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-011 inst_wr_addr  output  5  instruction-memory write address.
REQ-012 inst_wr_data  output  20  instruction word.
REQ-013 cpu_run  output  1  drives the CPU's inst_mem_read_write input: 0 = load, 1 = run/fetch.
REQ-014 cpu_halted  input  1  CPU halted flag.
REQ-015 busy, done, err  output  1 each  status flags.
REQ-016 inst_count  output  6  instructions written in the current session.

Function
REQ-017 FSM states: IDLE, LOAD, PAD, RUN, DONE.
REQ-018 IDLE/DONE --start--> LOAD; on entry, the address, count, byte index, err and done are cleared.
REQ-019 host_ready shall be 1 only in LOAD; a byte is taken when host_valid and host_ready are both 1.
REQ-020 Bytes are assembled little-endian: byte0 -> [7:0], byte1 -> [15:8], byte2[3:0] -> [19:16]; byte2[7:4] are ignored.
REQ-021 inst_wr_en shall pulse in the cycle after the byte2 handshake, with inst_wr_addr = inst_count[4:0]; inst_count increments in that same cycle.
REQ-022 If the 33rd or a later instruction completes, it shall be discarded with no write, and err is set.
REQ-023 host_last on byte2: after the write, go to PAD (HALT_PAD_EN) or RUN.
REQ-024 host_last on byte0 or byte1: discard the partial word, set err, and go to DONE with cpu_run held at 0.
REQ-025 RUN: cpu_run = 1 beginning the cycle after the final write; wait for cpu_halted = 1, then go to DONE.
REQ-026 DONE: cpu_run returns to 0; done = 1 until the next start.
REQ-027 busy = 1 in LOAD, PAD and RUN.
REQ-028 start outside IDLE/DONE shall be ignored.
REQ-029 host_valid outside LOAD shall be ignored, with no side effects.

Reset
REQ-030 On rst = 0: state = IDLE; host_ready, inst_wr_en, cpu_run, busy, done and err = 0; inst_wr_addr, inst_wr_data and inst_count = 0.
REQ-031 Reset asserted mid-LOAD or mid-RUN shall abort immediately; a partially assembled word is lost.

Configuration
REQ-032 Macro PROG_LOADER_HALT_PAD_EN: when defined, PAD writes the halt word 20'hC0000 (op 11) at address inst_count in one cycle, and only if inst_count < IMEM_DEPTH; it then goes to RUN.
REQ-033 Without PROG_LOADER_HALT_PAD_EN: the PAD state does not exist, LOAD goes directly to RUN, and the program must supply its own halt.

Structure
REQ-034 Shared package cpu_pkg holds:
- opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_HALT = 2'b11;
- INST_W and IMEM_DEPTH;
- field positions OP [19:18], SRC1 [17:12], SRC2 [11:6], DST [5:0];
- HALT_WORD;
- the FSM state enum.
REQ-035 One sub-module, inst_assembler, performs the byte-to-word packing and the byte index counter (0..2); the FSM, address and status logic stay in prog_loader.

Verification
REQ-036 Two-instruction program: start, then bytes 0x3F,0x10,0x00, 0x05,0x20,0x81 (last).
- Required writes: addr0 = 0x0103F, addr1 = 0x12005.
- inst_count = 2; cpu_run rises one cycle after the second write.
REQ-037 With PROG_LOADER_HALT_PAD_EN, same stream as REQ-036: a third write, addr2 = 0xC0000, precedes cpu_run = 1; inst_count = 3.
REQ-038 Stream of 33 words: writes occur for addresses 0..31 only, err = 1, and inst_count stops at 32.
REQ-039 host_last on the second byte of word 0: no write, err = 1, state = DONE, cpu_run stays 0.
REQ-040 In RUN, cpu_halted raised at cycle N: done = 1 and cpu_run = 0 at cycle N+1; a subsequent start clears done and err.
REQ-041 rst pulsed low mid-LOAD after 1.5 words: all outputs return to 0 asynchronously, and the next session starts writing at address 0.
